// File: rtl/uart_dbg_pkg.sv
// rtl/uart_dbg_pkg.sv - command codes, response bytes and FSM states for the UART debug master
package uart_dbg_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    STRB,
    BUS_WR,
    BUS_RD,
    RD_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/uart_dbg_master_timer.sv
// rtl/uart_dbg_master_timer.sv - inter-byte idle counter that flags an abandoned command
module dbg_byte_timer #(
  parameter int unsigned LIMIT = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  // Saturates at the limit so expired stays asserted until the FSM leaves the field states.
  assign expired = enable && (count_q == LIMIT_V);

  // Next count: cleared by any accepted byte or outside field states, else counts idle cycles.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_dbg_master.sv
// rtl/uart_dbg_master.sv - UART command decoder issuing single-beat SRAM-bus reads and writes
module uart_dbg_master
  import uart_dbg_pkg::*;
#(
  parameter int LEN_ADDR       = 64,
  parameter int LEN_DATA       = 64,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [LEN_ADDR-1:0]   addra,
  output logic [LEN_DATA-1:0]   dina,
  input  logic [LEN_DATA-1:0]   douta,
  output logic                  ena,
  output logic [LEN_DATA/8-1:0] wea,
  output logic                  cpu_hold
);

  localparam int AB = LEN_ADDR / 8;
  localparam int DB = LEN_DATA / 8;

  state_t                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [LEN_ADDR-1:0]   addr_q, addr_d;
  logic [LEN_DATA-1:0]   data_q, data_d;
  logic [DB-1:0]         strb_q, strb_d;
  logic [LEN_ADDR-1:0]   addra_q, addra_d;
  logic [LEN_DATA-1:0]   dina_q, dina_d;
  logic [LEN_DATA-1:0]   resp_q, resp_d;
  logic [3:0]            left_q, left_d;
  logic                  hold_q, hold_d;

  logic in_field;
  logic expired;
  logic rx_fire;

  assign in_field = (state_q == ADDR) || (state_q == DATA) || (state_q == STRB);
  // A field state that has timed out refuses the byte so it is not silently eaten.
  assign rx_ready = !rst && ((state_q == IDLE) || (in_field && !expired));
  assign rx_fire  = rx_valid && rx_ready;

  assign tx_valid = (state_q == RESP);
  assign tx_data  = resp_q[7:0];
  assign ena      = (state_q == BUS_WR) || (state_q == BUS_RD);
  assign wea      = (state_q == BUS_WR) ? strb_q : '0;
  // Bus address/data come from dedicated registers so they hold while the next command assembles.
  assign addra    = addra_q;
  assign dina     = dina_q;
  assign cpu_hold = hold_q;

  dbg_byte_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_fire || !in_field),
    .enable (in_field),
    .expired(expired)
  );

  // Command FSM: byte assembly, bus strobes and response sequencing.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    addra_d = addra_q;
    dina_d  = dina_q;
    resp_d  = resp_q;
    left_d  = left_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_fire) begin
          left_d = 4'd1;
          case (rx_data)
            CMD_W: begin
              is_wr_d = 1'b1;
              state_d = ADDR;
            end
            CMD_R: begin
              is_wr_d = 1'b0;
              state_d = ADDR;
            end
            CMD_H: begin
              hold_d  = 1'b1;
              resp_d  = LEN_DATA'(ACK);
              state_d = RESP;
            end
            CMD_G: begin
              hold_d  = 1'b0;
              resp_d  = LEN_DATA'(ACK);
              state_d = RESP;
            end
            default: begin
              resp_d  = LEN_DATA'(NAK);
              state_d = RESP;
            end
          endcase
        end
      end
      ADDR: begin
        if (expired) begin
          state_d = IDLE;
        end else if (rx_fire) begin
          addr_d = {rx_data, addr_q[LEN_ADDR-1:8]};
          if (cnt_q == 8'(AB - 1)) begin
            cnt_d = '0;
            if (is_wr_q) begin
              state_d = DATA;
            end else begin
              addra_d = addr_d;
              state_d = BUS_RD;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      DATA: begin
        if (expired) begin
          state_d = IDLE;
        end else if (rx_fire) begin
          data_d = {rx_data, data_q[LEN_DATA-1:8]};
          if (cnt_q == 8'(DB - 1)) begin
            cnt_d   = '0;
            state_d = STRB;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      STRB: begin
        if (expired) begin
          state_d = IDLE;
        end else if (rx_fire) begin
          strb_d  = rx_data[DB-1:0];
          addra_d = addr_q;
          dina_d  = data_q;
          state_d = BUS_WR;
        end
      end
      BUS_WR: begin
        resp_d  = LEN_DATA'(ACK);
        left_d  = 4'd1;
        state_d = RESP;
      end
      BUS_RD: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        resp_d  = douta;
        left_d  = 4'(DB);
        state_d = RESP;
      end
      RESP: begin
        if (tx_ready) begin
          if (left_q == 4'd1) begin
            state_d = IDLE;
          end else begin
            resp_d = resp_q >> 8;
            left_d = left_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      addra_q <= '0;
      dina_q  <= '0;
      resp_q  <= '0;
      left_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      resp_q  <= resp_d;
      left_q  <= left_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_uart_dbg_master.sv
// tb/tb_uart_dbg_master.sv - directed self-checking bench for uart_dbg_master
module tb_uart_dbg_master;
  import uart_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [63:0] addra;
  logic [63:0] dina;
  logic [63:0] douta = 64'h0;
  logic        ena;
  logic [7:0]  wea;
  logic        cpu_hold;

  always #5 clk = ~clk;

  uart_dbg_master #(
    .LEN_ADDR(64),
    .LEN_DATA(64),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .addra   (addra),
    .dina    (dina),
    .douta   (douta),
    .ena     (ena),
    .wea     (wea),
    .cpu_hold(cpu_hold)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  int          ena_cnt = 0;
  int          wea_stray = 0;
  int          tx_seen = 0;
  logic [63:0] last_addr = 64'h0;
  logic [63:0] last_dina = 64'h0;
  logic [7:0]  last_wea = 8'h0;
  logic        rd_pend = 1'b0;
  logic [63:0] rd_value = 64'hDEADBEEFCAFEF00D;

  logic [7:0]  exp_rd [8] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [63:0] wr_addr = 64'h0000_0000_8000_0010;
  logic [63:0] wr_data = 64'h1122_3344_5566_7788;

  // Bus responder/monitor: read data appears only in the cycle after the read strobe.
  always @(negedge clk) begin
    douta = rd_pend ? rd_value : 64'h0;
    rd_pend = ena && (wea == 8'h0);
    if (ena) begin
      ena_cnt++;
      last_addr = addra;
      last_dina = dina;
      last_wea  = wea;
    end
    if (!ena && wea != 8'h0) wea_stray++;
    if (tx_valid) tx_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic wait_expired(input string name);
    total_cnt++;
    $display("FAIL %s: got no handshake required handshake within 200 cycles", name);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) wait_expired("rx_accept");
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input string name, input int stall, output logic [7:0] b, output int lat);
    logic       ok = 1'b1;
    logic [7:0] first;
    lat = 0;
    @(negedge clk);
    while (!tx_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) begin
      wait_expired(name);
      b = 8'h00;
      return;
    end
    first = tx_data;
    for (int i = 0; i < stall; i++) begin
      if (!tx_valid || tx_data !== first || rx_ready) ok = 1'b0;
      @(negedge clk);
    end
    if (stall > 0) check({name, "_stall_stable"}, 64'(ok), 64'd1);
    tx_ready = 1'b1;
    b = tx_data;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic do_write(input string name);
    int         e0 = ena_cnt;
    logic [7:0] b;
    int         lat;
    send_byte(CMD_W);
    for (int i = 0; i < 8; i++) send_byte(wr_addr[8*i +: 8]);
    for (int i = 0; i < 8; i++) send_byte(wr_data[8*i +: 8]);
    send_byte(8'hFF);
    recv_byte({name, "_ack"}, 0, b, lat);
    check({name, "_ack"}, 64'(b), 64'h06);
    check({name, "_ena_cycles"}, 64'(ena_cnt - e0), 64'd1);
    check({name, "_addra"}, last_addr, 64'h0000_0000_8000_0010);
    check({name, "_dina"}, last_dina, 64'h1122_3344_5566_7788);
    check({name, "_wea"}, 64'(last_wea), 64'hFF);
  endtask

  task automatic do_read(input string name, input int stall);
    int         e0 = ena_cnt;
    logic [7:0] b;
    int         lat;
    send_byte(CMD_R);
    for (int i = 0; i < 8; i++) send_byte(wr_addr[8*i +: 8]);
    for (int i = 0; i < 8; i++) begin
      recv_byte({name, "_byte"}, stall, b, lat);
      check($sformatf("%s_byte%0d", name, i), 64'(b), 64'(exp_rd[i]));
      if (i > 0 && stall == 0) check($sformatf("%s_gap%0d", name, i), 64'(lat), 64'd0);
    end
    check({name, "_ena_cycles"}, 64'(ena_cnt - e0), 64'd1);
    check({name, "_wea"}, 64'(last_wea), 64'h0);
    check({name, "_addra"}, last_addr, 64'h0000_0000_8000_0010);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] exp_tx;
    logic       exp_hold;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] b;
    int         lat;
    int         e0;

    vecs[0] = '{cmd: 8'h41, exp_tx: 8'h15, exp_hold: 1'b0};
    vecs[1] = '{cmd: 8'h48, exp_tx: 8'h06, exp_hold: 1'b1};
    vecs[2] = '{cmd: 8'h00, exp_tx: 8'h15, exp_hold: 1'b1};
    vecs[3] = '{cmd: 8'h47, exp_tx: 8'h06, exp_hold: 1'b0};
    vecs[4] = '{cmd: 8'hFF, exp_tx: 8'h15, exp_hold: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_ena", 64'(ena), 64'd0);
    check("rst_wea", 64'(wea), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_addra", addra, 64'd0);
    check("rst_dina", dina, 64'd0);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-byte commands from the table.
    for (int i = 0; i < 5; i++) begin
      e0 = ena_cnt;
      send_byte(vecs[i].cmd);
      recv_byte($sformatf("vec%0d", i), 0, b, lat);
      check($sformatf("vec%0d_tx", i), 64'(b), 64'(vecs[i].exp_tx));
      check($sformatf("vec%0d_hold", i), 64'(cpu_hold), 64'(vecs[i].exp_hold));
      check($sformatf("vec%0d_no_ena", i), 64'(ena_cnt - e0), 64'd0);
    end

    do_write("wr1");
    do_read("rd1", 0);

    // Abandoned write: five address bytes then silence.
    e0 = ena_cnt;
    send_byte(CMD_W);
    for (int i = 0; i < 5; i++) send_byte(wr_addr[8*i +: 8]);
    tx_seen = 0;
    repeat (40) @(negedge clk);
    check("to_still_addr", 64'(dut.state_q), 64'(ADDR));
    repeat (20) @(negedge clk);
    check("to_idle", 64'(dut.state_q), 64'(IDLE));
    check("to_no_ena", 64'(ena_cnt - e0), 64'd0);
    check("to_no_tx", 64'(tx_seen), 64'd0);
    do_read("rd_after_to", 0);

    do_read("rd_stall", 20);

    // Reset in the middle of the data phase with the pipeline held.
    send_byte(CMD_H);
    recv_byte("hold_ack", 0, b, lat);
    check("hold_ack", 64'(b), 64'h06);
    check("hold_set", 64'(cpu_hold), 64'd1);
    send_byte(CMD_W);
    for (int i = 0; i < 8; i++) send_byte(wr_addr[8*i +: 8]);
    for (int i = 0; i < 3; i++) send_byte(wr_data[8*i +: 8]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
    @(posedge clk);
    #1;
    check("mid_rst_ena", 64'(ena), 64'd0);
    check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("mid_rst_state", 64'(dut.state_q), 64'(IDLE));
    rst = 1'b0;
    do_write("wr_after_rst");

    check("wea_outside_bus_wr", 64'(wea_stray), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
